// File: rtl/prq_cam_wildcard_pkg.sv
// Shared types for the posted-receive-queue matcher and future queue variants.
package prq_pkg;

  localparam int unsigned RANK_BIT  = 8;
  localparam int unsigned TAG_BIT   = 8;
  localparam int unsigned COMM_BIT  = 2;
  localparam int unsigned PTR_WIDTH = 32;

  // One posted receive at the default field widths.
  typedef struct packed {
    logic [RANK_BIT-1:0]  rank;
    logic [TAG_BIT-1:0]   tag;
    logic [COMM_BIT-1:0]  comm;
    logic                 any_rank;
    logic                 any_tag;
    logic [PTR_WIDTH-1:0] data_ptr;
  } prq_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StResp
  } prq_state_e;

endpackage

// File: rtl/prq_cam_wildcard_if.sv
// Insert/lookup/status bundle between the request path, the network path and the PRQ.
interface prq_cam_wildcard_if
  import prq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned RANK_BIT  = prq_pkg::RANK_BIT,
  parameter int unsigned TAG_BIT   = prq_pkg::TAG_BIT,
  parameter int unsigned COMM_BIT  = prq_pkg::COMM_BIT,
  parameter int unsigned PTR_WIDTH = prq_pkg::PTR_WIDTH
) ();

  logic                         insert;
  logic [RANK_BIT-1:0]          ins_rank;
  logic [TAG_BIT-1:0]           ins_tag;
  logic [COMM_BIT-1:0]          ins_comm;
  logic                         ins_any_rank;
  logic                         ins_any_tag;
  logic [PTR_WIDTH-1:0]         ins_data_ptr;
  logic                         insert_drop;

  logic                         find;
  logic [RANK_BIT-1:0]          msg_rank;
  logic [TAG_BIT-1:0]           msg_tag;
  logic [COMM_BIT-1:0]          msg_comm;
  logic                         busy;
  logic                         found;
  logic                         not_found;
  logic [PTR_WIDTH-1:0]         posted_request;

  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         q_empty;
  logic                         q_full;

  modport master (
    output insert, ins_rank, ins_tag, ins_comm, ins_any_rank, ins_any_tag, ins_data_ptr,
    output find, msg_rank, msg_tag, msg_comm,
    input  insert_drop, busy, found, not_found, posted_request, count, q_empty, q_full
  );

  modport slave (
    input  insert, ins_rank, ins_tag, ins_comm, ins_any_rank, ins_any_tag, ins_data_ptr,
    input  find, msg_rank, msg_tag, msg_comm,
    output insert_drop, busy, found, not_found, posted_request, count, q_empty, q_full
  );

endinterface

// File: rtl/prq_cam_wildcard_first_match.sv
// Lowest-set-bit priority encoder: index 0 has highest priority.
module prq_first_match
  import prq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic [DEPTH-1:0]         req_i,
  output logic                     hit_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    hit_o = |req_i;
    idx_o = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/prq_cam_wildcard.sv
// Posted-receive queue with wildcard match; oldest matching entry wins.
module prq_cam_wildcard
  import prq_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned RANK_BIT  = prq_pkg::RANK_BIT,
  parameter int unsigned TAG_BIT   = prq_pkg::TAG_BIT,
  parameter int unsigned COMM_BIT  = prq_pkg::COMM_BIT,
  parameter int unsigned PTR_WIDTH = prq_pkg::PTR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  prq_cam_wildcard_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef struct packed {
    logic [RANK_BIT-1:0]  rank;
    logic [TAG_BIT-1:0]   tag;
    logic [COMM_BIT-1:0]  comm;
    logic                 any_rank;
    logic                 any_tag;
    logic [PTR_WIDTH-1:0] data_ptr;
  } entry_t;

  entry_t               entry_q [DEPTH];
  entry_t               entry_d [DEPTH];
  entry_t               new_entry;
  logic [CntW-1:0]      count_q, count_d, wr_pos;
  logic                 q_empty_q, q_empty_d, q_full_q, q_full_d;
  logic                 drop_q, drop_d;

  prq_state_e           state_q, state_d;
  logic [RANK_BIT-1:0]  hdr_rank_q, hdr_rank_d;
  logic [TAG_BIT-1:0]   hdr_tag_q, hdr_tag_d;
  logic [COMM_BIT-1:0]  hdr_comm_q, hdr_comm_d;
  logic [DEPTH-1:0]     match_q, match_d, match_now;
  logic                 found_q, found_d, not_found_q, not_found_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;

  logic                 hit;
  logic [IdxW-1:0]      hit_idx;
  logic                 remove;
  logic                 ins_ok;

  prq_first_match #(
    .DEPTH(DEPTH)
  ) u_first_match (
    .req_i(match_q),
    .hit_o(hit),
    .idx_o(hit_idx)
  );

  // Per-entry comparators against the captured header; communicator is never wildcarded.
  always_comb begin
    match_now = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_now[i] = (CntW'(i) < count_q) &&
                     (entry_q[i].comm == hdr_comm_q) &&
                     (entry_q[i].any_rank || (entry_q[i].rank == hdr_rank_q)) &&
                     (entry_q[i].any_tag  || (entry_q[i].tag  == hdr_tag_q));
    end
  end

  // Lookup FSM: capture header, register match vector, respond and remove.
  always_comb begin
    state_d     = state_q;
    hdr_rank_d  = hdr_rank_q;
    hdr_tag_d   = hdr_tag_q;
    hdr_comm_d  = hdr_comm_q;
    match_d     = match_q;
    found_d     = 1'b0;
    not_found_d = 1'b0;
    ptr_d       = '0;
    remove      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.find) begin
          hdr_rank_d = bus.msg_rank;
          hdr_tag_d  = bus.msg_tag;
          hdr_comm_d = bus.msg_comm;
          state_d    = StCmp;
        end
      end
      StCmp: begin
        match_d = match_now;
        state_d = StResp;
      end
      StResp: begin
        if (hit) begin
          found_d = 1'b1;
          ptr_d   = entry_q[hit_idx].data_ptr;
          remove  = 1'b1;
        end else begin
          not_found_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Entry array: shift down above a removed slot, then append any accepted insert.
  always_comb begin
    new_entry = '{rank: bus.ins_rank, tag: bus.ins_tag, comm: bus.ins_comm,
                  any_rank: bus.ins_any_rank, any_tag: bus.ins_any_tag,
                  data_ptr: bus.ins_data_ptr};
    // A same-edge removal frees a slot, so a full queue can still accept.
    ins_ok = bus.insert && ((count_q != CntW'(DEPTH)) || remove);
    drop_d = bus.insert && !ins_ok;
    wr_pos = remove ? (count_q - CntW'(1)) : count_q;
    for (int i = 0; i < int'(DEPTH); i++) entry_d[i] = entry_q[i];
    if (remove) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (IdxW'(i) >= hit_idx) entry_d[i] = entry_q[i+1];
      end
    end
    if (ins_ok) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CntW'(i) == wr_pos) entry_d[i] = new_entry;
      end
    end
    count_d   = count_q + CntW'(ins_ok) - CntW'(remove);
    q_empty_d = (count_d == '0);
    q_full_d  = (count_d == CntW'(DEPTH));
  end

  // State, queue and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hdr_rank_q  <= '0;
      hdr_tag_q   <= '0;
      hdr_comm_q  <= '0;
      match_q     <= '0;
      found_q     <= 1'b0;
      not_found_q <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      q_empty_q   <= 1'b1;
      q_full_q    <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      hdr_rank_q  <= hdr_rank_d;
      hdr_tag_q   <= hdr_tag_d;
      hdr_comm_q  <= hdr_comm_d;
      match_q     <= match_d;
      found_q     <= found_d;
      not_found_q <= not_found_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      q_empty_q   <= q_empty_d;
      q_full_q    <= q_full_d;
      drop_q      <= drop_d;
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= entry_d[i];
    end
  end

  assign bus.insert_drop    = drop_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.found          = found_q;
  assign bus.not_found      = not_found_q;
  assign bus.posted_request = ptr_q;
  assign bus.count          = count_q;
  assign bus.q_empty        = q_empty_q;
  assign bus.q_full         = q_full_q;

endmodule

// File: tb/tb_prq_cam_wildcard.sv
// Directed bench for prq_cam_wildcard: vector table plus multi-cycle corner sequences.
module tb_prq_cam_wildcard;
  import prq_pkg::*;

  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prq_cam_wildcard_if #(
    .DEPTH(Depth), .RANK_BIT(RANK_BIT), .TAG_BIT(TAG_BIT), .COMM_BIT(COMM_BIT),
    .PTR_WIDTH(PTR_WIDTH)
  ) bus_if ();

  prq_cam_wildcard #(
    .DEPTH(Depth), .RANK_BIT(RANK_BIT), .TAG_BIT(TAG_BIT), .COMM_BIT(COMM_BIT),
    .PTR_WIDTH(PTR_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct {
    bit          is_find;
    prq_entry_t  e;
    bit          exp_found;
    logic [31:0] exp_ptr;
    int          exp_count;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic prq_entry_t ent(input int r, input int t, input int c, input bit ar,
                                     input bit at, input logic [31:0] p);
    prq_entry_t e;
    e.rank     = RANK_BIT'(r);
    e.tag      = TAG_BIT'(t);
    e.comm     = COMM_BIT'(c);
    e.any_rank = ar;
    e.any_tag  = at;
    e.data_ptr = p;
    return e;
  endfunction

  function automatic vec_t mk_ins(input prq_entry_t e, input int cnt);
    vec_t v;
    v.is_find = 1'b0; v.e = e; v.exp_found = 1'b0; v.exp_ptr = '0; v.exp_count = cnt;
    return v;
  endfunction

  function automatic vec_t mk_find(input int r, input int t, input int c, input bit f,
                                   input logic [31:0] p, input int cnt);
    vec_t v;
    v.is_find = 1'b1; v.e = ent(r, t, c, 1'b0, 1'b0, '0);
    v.exp_found = f; v.exp_ptr = p; v.exp_count = cnt;
    return v;
  endfunction

  task automatic idle_inputs();
    bus_if.insert = 1'b0; bus_if.ins_rank = '0; bus_if.ins_tag = '0; bus_if.ins_comm = '0;
    bus_if.ins_any_rank = 1'b0; bus_if.ins_any_tag = 1'b0; bus_if.ins_data_ptr = '0;
    bus_if.find = 1'b0; bus_if.msg_rank = '0; bus_if.msg_tag = '0; bus_if.msg_comm = '0;
  endtask

  task automatic drive_ins(input prq_entry_t e);
    bus_if.insert       = 1'b1;
    bus_if.ins_rank     = e.rank;
    bus_if.ins_tag      = e.tag;
    bus_if.ins_comm     = e.comm;
    bus_if.ins_any_rank = e.any_rank;
    bus_if.ins_any_tag  = e.any_tag;
    bus_if.ins_data_ptr = e.data_ptr;
  endtask

  task automatic drive_find(input int r, input int t, input int c);
    bus_if.find     = 1'b1;
    bus_if.msg_rank = RANK_BIT'(r);
    bus_if.msg_tag  = TAG_BIT'(t);
    bus_if.msg_comm = COMM_BIT'(c);
  endtask

  task automatic do_insert(input prq_entry_t e);
    drive_ins(e);
    step();
    bus_if.insert = 1'b0;
  endtask

  // Returns the result sampled just after edge N+2.
  task automatic do_find(input int r, input int t, input int c, output logic f,
                         output logic nf, output logic [31:0] p);
    drive_find(r, t, c);
    step();
    bus_if.find = 1'b0;
    step();
    step();
    f  = bus_if.found;
    nf = bus_if.not_found;
    p  = bus_if.posted_request;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic        f, nf;
    logic [31:0] p;
    bit          seen;

    idle_inputs();
    #12;
    chk("rst_count", 32'(bus_if.count), 0);
    chk("rst_q_empty", 32'(bus_if.q_empty), 1);
    chk("rst_q_full", 32'(bus_if.q_full), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_found", 32'(bus_if.found), 0);
    chk("rst_not_found", 32'(bus_if.not_found), 0);
    chk("rst_posted_request", bus_if.posted_request, 0);
    chk("rst_insert_drop", 32'(bus_if.insert_drop), 0);
    rst_n = 1'b1;
    step();

    // Latency and busy window; a second find while busy is ignored.
    do_insert(ent(3, 5, 0, 0, 0, 32'h100));
    chk("lat_count_ins", 32'(bus_if.count), 1);
    drive_find(3, 5, 0);
    step();
    chk("lat_busy_n0", 32'(bus_if.busy), 1);
    chk("lat_found_n0", 32'(bus_if.found), 0);
    drive_find(3, 5, 0);
    step();
    bus_if.find = 1'b0;
    chk("lat_busy_n1", 32'(bus_if.busy), 1);
    chk("lat_found_n1", 32'(bus_if.found), 0);
    step();
    chk("lat_found_n2", 32'(bus_if.found), 1);
    chk("lat_ptr_n2", bus_if.posted_request, 32'h100);
    chk("lat_busy_n2", 32'(bus_if.busy), 0);
    chk("lat_count_n2", 32'(bus_if.count), 0);
    chk("lat_q_empty_n2", 32'(bus_if.q_empty), 1);
    step();
    chk("lat_found_n3", 32'(bus_if.found), 0);
    chk("lat_not_found_n3", 32'(bus_if.not_found), 0);
    chk("lat_ptr_n3", bus_if.posted_request, 0);
    chk("lat_busy_n3", 32'(bus_if.busy), 0);

    // Directed table.
    vecs.push_back(mk_ins(ent(3, 5, 0, 0, 0, 32'h100), 1));
    vecs.push_back(mk_find(3, 5, 0, 1, 32'h100, 0));
    vecs.push_back(mk_ins(ent(0, 7, 0, 1, 0, 32'hA), 1));
    vecs.push_back(mk_ins(ent(2, 7, 0, 0, 0, 32'hB), 2));
    vecs.push_back(mk_find(2, 7, 0, 1, 32'hA, 1));
    vecs.push_back(mk_find(2, 7, 0, 1, 32'hB, 0));
    vecs.push_back(mk_find(1, 1, 1, 0, 0, 0));
    vecs.push_back(mk_ins(ent(1, 1, 0, 0, 0, 32'hC), 1));
    vecs.push_back(mk_find(1, 1, 1, 0, 0, 1));
    vecs.push_back(mk_find(9, 1, 0, 0, 0, 1));
    vecs.push_back(mk_ins(ent(4, 0, 1, 0, 1, 32'hD), 2));
    vecs.push_back(mk_find(4, 99, 1, 1, 32'hD, 1));
    vecs.push_back(mk_find(1, 1, 0, 1, 32'hC, 0));
    vecs.push_back(mk_ins(ent(5, 5, 2, 0, 0, 32'hE), 1));
    vecs.push_back(mk_ins(ent(5, 5, 2, 0, 0, 32'hF), 2));
    vecs.push_back(mk_find(5, 5, 2, 1, 32'hE, 1));
    vecs.push_back(mk_find(5, 5, 2, 1, 32'hF, 0));
    vecs.push_back(mk_ins(ent(0, 0, 3, 1, 1, 32'h77), 1));
    vecs.push_back(mk_find(200, 201, 3, 1, 32'h77, 0));

    foreach (vecs[i]) begin
      if (vecs[i].is_find) begin
        do_find(int'(vecs[i].e.rank), int'(vecs[i].e.tag), int'(vecs[i].e.comm), f, nf, p);
        chk($sformatf("row%0d_found", i), 32'(f), 32'(vecs[i].exp_found));
        chk($sformatf("row%0d_not_found", i), 32'(nf), 32'(!vecs[i].exp_found));
        chk($sformatf("row%0d_ptr", i), p, vecs[i].exp_found ? vecs[i].exp_ptr : 32'h0);
      end else begin
        do_insert(vecs[i].e);
        chk($sformatf("row%0d_q_empty", i), 32'(bus_if.q_empty), 32'(vecs[i].exp_count == 0));
      end
      chk($sformatf("row%0d_count", i), 32'(bus_if.count), 32'(vecs[i].exp_count));
    end

    // Insert on the same edge as find is visible to that find.
    drive_ins(ent(8, 8, 0, 0, 0, 32'h88));
    drive_find(8, 8, 0);
    step();
    bus_if.insert = 1'b0;
    bus_if.find   = 1'b0;
    step();
    step();
    chk("same_edge_found", 32'(bus_if.found), 1);
    chk("same_edge_ptr", bus_if.posted_request, 32'h88);
    chk("same_edge_count", 32'(bus_if.count), 0);

    // Insert during CMP is invisible to the in-flight find, visible to the next.
    drive_find(6, 6, 0);
    step();
    bus_if.find = 1'b0;
    drive_ins(ent(6, 6, 0, 0, 0, 32'h66));
    step();
    bus_if.insert = 1'b0;
    chk("cmp_ins_busy", 32'(bus_if.busy), 1);
    step();
    chk("cmp_ins_not_found", 32'(bus_if.not_found), 1);
    chk("cmp_ins_found", 32'(bus_if.found), 0);
    chk("cmp_ins_count", 32'(bus_if.count), 1);
    do_find(6, 6, 0, f, nf, p);
    chk("cmp_ins_next_found", 32'(f), 1);
    chk("cmp_ins_next_ptr", p, 32'h66);
    chk("cmp_ins_next_count", 32'(bus_if.count), 0);

    // Fill; entry 15 carries key {50,50} so ordering against a later duplicate is visible.
    for (int i = 0; i < int'(Depth); i++) begin
      do_insert(ent((i == 15) ? 50 : i, (i == 15) ? 50 : i, 0, 0, 0, 32'h200 + 32'(i)));
    end
    chk("full_count", 32'(bus_if.count), 16);
    chk("full_q_full", 32'(bus_if.q_full), 1);
    chk("full_q_empty", 32'(bus_if.q_empty), 0);
    drive_ins(ent(50, 50, 0, 0, 0, 32'h999));
    step();
    bus_if.insert = 1'b0;
    chk("drop_pulse", 32'(bus_if.insert_drop), 1);
    chk("drop_count", 32'(bus_if.count), 16);
    step();
    chk("drop_pulse_end", 32'(bus_if.insert_drop), 0);

    // Insert on the RESP edge of a successful find while full.
    drive_find(0, 0, 0);
    step();
    bus_if.find = 1'b0;
    step();
    drive_ins(ent(50, 50, 0, 0, 0, 32'h5050));
    step();
    bus_if.insert = 1'b0;
    chk("full_swap_found", 32'(bus_if.found), 1);
    chk("full_swap_ptr", bus_if.posted_request, 32'h200);
    chk("full_swap_count", 32'(bus_if.count), 16);
    chk("full_swap_q_full", 32'(bus_if.q_full), 1);
    chk("full_swap_no_drop", 32'(bus_if.insert_drop), 0);
    do_find(50, 50, 0, f, nf, p);
    chk("full_old_dup_ptr", p, 32'h20F);
    chk("full_old_dup_count", 32'(bus_if.count), 15);
    do_find(50, 50, 0, f, nf, p);
    chk("full_new_dup_ptr", p, 32'h5050);
    chk("full_new_dup_count", 32'(bus_if.count), 14);
    do_find(50, 50, 0, f, nf, p);
    chk("full_dropped_absent", 32'(nf), 1);
    chk("full_dropped_count", 32'(bus_if.count), 14);

    // Asynchronous reset mid-lookup: immediate clear and no result pulse.
    drive_find(1, 1, 0);
    step();
    bus_if.find = 1'b0;
    chk("rst_cmp_busy_before", 32'(bus_if.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cmp_busy", 32'(bus_if.busy), 0);
    chk("rst_cmp_count", 32'(bus_if.count), 0);
    chk("rst_cmp_ptr", bus_if.posted_request, 0);
    chk("rst_cmp_found", 32'(bus_if.found), 0);
    chk("rst_cmp_not_found", 32'(bus_if.not_found), 0);
    chk("rst_cmp_q_empty", 32'(bus_if.q_empty), 1);
    chk("rst_cmp_q_full", 32'(bus_if.q_full), 0);
    seen = 1'b0;
    repeat (2) begin
      step();
      seen |= bus_if.found | bus_if.not_found;
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      seen |= bus_if.found | bus_if.not_found;
    end
    chk("rst_cmp_no_pulse", 32'(seen), 0);
    do_find(1, 1, 0, f, nf, p);
    chk("post_rst_not_found", 32'(nf), 1);
    chk("post_rst_count", 32'(bus_if.count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
